// File: rtl/node_packet_tx.sv
// node_packet_tx
//   Transmit-side packetiser for a node's photonic interface. Words are
//   buffered FIFO-style while idle; a start request for a valid destination
//   raises tx_req, and on grant the block emits one control packet
//   {dest, word_count}, one idle cycle, then one {node_id, word} data packet
//   per cycle, followed by a one-cycle done pulse.
//
// Ports
//   clk               system clock, rising edge
//   rst               asynchronous active-low reset
//   node_id[15:0]     this node's ID (upper half of each data packet)
//   max_node[15:0]    number of nodes; valid destinations are 0..max_node-1
//   wr_en, wr_data    buffer write (accepted when wr_ready)
//   wr_ready          IDLE and buffer not full
//   start, dest_node  send request and destination (sampled on accept)
//   tx_grant, tx_req  channel arbitration handshake
//   control_tx_packet registered control packet, 0 otherwise
//   data_tx_packet    registered data packet, 0 otherwise
//   busy              any state other than IDLE
//   done              pulse after the last data packet
//   err               pulse when start is rejected for a bad destination
module node_packet_tx #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] node_id,
  input  logic [15:0] max_node,
  input  logic        wr_en,
  input  logic [15:0] wr_data,
  output logic        wr_ready,
  input  logic        start,
  input  logic [15:0] dest_node,
  input  logic        tx_grant,
  output logic        tx_req,
  output logic [31:0] control_tx_packet,
  output logic [31:0] data_tx_packet,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_CTRL,
    S_GAP,
    S_DATA,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [15:0]        mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]   count_q;
  logic [15:0]        dest_q;
  logic [31:0]        ctrl_q, data_q;
  logic               done_q, err_q;

  logic               wr_accept;
  logic [CNT_W-1:0]   cnt_eff;
  logic               dest_bad;
  logic               launch, flush;

  assign wr_ready  = (state_q == S_IDLE) && (count_q != CNT_W'(DEPTH));
  assign wr_accept = wr_en && wr_ready;
  // A write in the same cycle as start is counted in the transfer.
  assign cnt_eff   = count_q + CNT_W'(wr_accept);
  assign dest_bad  = (dest_node >= max_node) || (dest_node == node_id);

  assign tx_req            = (state_q == S_REQ);
  assign busy              = (state_q != S_IDLE);
  assign control_tx_packet = ctrl_q;
  assign data_tx_packet    = data_q;
  assign done              = done_q;
  assign err               = err_q;

  always_comb begin
    state_d = state_q;
    launch  = 1'b0;
    flush   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start && (cnt_eff != '0)) begin
          if (dest_bad) begin
            flush = 1'b1;
          end else begin
            launch  = 1'b1;
            state_d = S_REQ;
          end
        end
      end
      S_REQ:   if (tx_grant) state_d = S_CTRL;
      S_CTRL:  state_d = S_GAP;
      S_GAP:   state_d = S_DATA;
      // count_q holds the words still to send while in DATA.
      S_DATA:  if (count_q == CNT_W'(1)) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // Buffer storage needs no reset; occupancy is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (wr_accept) mem_q[wr_ptr_q] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      dest_q   <= '0;
      ctrl_q   <= '0;
      data_q   <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      if (wr_accept) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (state_q == S_DATA) rd_ptr_q <= rd_ptr_q + PTR_W'(1);

      if (flush) begin
        count_q  <= '0;
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else if (launch) begin
        count_q <= cnt_eff;
      end else if (wr_accept) begin
        count_q <= count_q + CNT_W'(1);
      end else if (state_q == S_DATA) begin
        count_q <= count_q - CNT_W'(1);
      end

      if (launch) dest_q <= dest_node;

      // Outputs are registered from the current state, so each packet
      // appears one edge after its state is entered.
      ctrl_q <= (state_q == S_CTRL) ? {dest_q, 16'(count_q)} : '0;
      data_q <= (state_q == S_DATA) ? {node_id, mem_q[rd_ptr_q]} : '0;
      done_q <= (state_q == S_DONE);
      err_q  <= flush;
    end
  end

endmodule

// File: tb/tb_node_packet_tx.sv
module tb_node_packet_tx;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] node_id, max_node, wr_data, dest_node;
  logic        wr_en, start, tx_grant;
  logic        wr_ready, tx_req, busy, done, err;
  logic [31:0] control_tx_packet, data_tx_packet;

  node_packet_tx #(.DEPTH(8)) dut (
    .clk(clk), .rst(rst_n), .node_id(node_id), .max_node(max_node),
    .wr_en(wr_en), .wr_data(wr_data), .wr_ready(wr_ready),
    .start(start), .dest_node(dest_node), .tx_grant(tx_grant),
    .tx_req(tx_req), .control_tx_packet(control_tx_packet),
    .data_tx_packet(data_tx_packet), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // kind: 0 control, 1 data, 2 done, 3 err
  typedef struct { int kind; logic [31:0] val; } ev_t;
  ev_t exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic push(input int kind, input logic [31:0] val);
    ev_t e;
    e.kind = kind;
    e.val  = val;
    exp_q.push_back(e);
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents an output event,
  // and checks burst timing relative to the control packet.
  int ctrl_cyc = 0;
  int n_data   = 0;
  task automatic observe(input int kind, input logic [31:0] val);
    ev_t e;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL unexpected_event: got kind %0d value %h expected none", kind, val);
    end else begin
      e = exp_q.pop_front();
      chk($sformatf("event_kind%0d", e.kind), kind, e.kind);
      chk($sformatf("event_val%0d", e.kind), val, e.val);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (control_tx_packet != '0) begin
        observe(0, control_tx_packet);
        ctrl_cyc = cyc;
        n_data   = 0;
      end
      if (data_tx_packet != '0) begin
        observe(1, data_tx_packet);
        chk("data_timing", cyc, ctrl_cyc + 2 + n_data);
        n_data++;
      end
      if (done) begin
        observe(2, 32'h1);
        chk("done_timing", cyc, ctrl_cyc + 2 + n_data);
      end
      if (err) observe(3, 32'h1);
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic write(input logic [15:0] w);
    wr_en = 1'b1;
    wr_data = w;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic send(input logic [15:0] d);
    start = 1'b1;
    dest_node = d;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle;
    int k;
    k = 0;
    while (busy && k < 200) begin
      tick();
      k++;
    end
    if (busy) begin
      n_cmp++;
      n_bad++;
      $display("FAIL wait_idle: got busy=1 expected 0 within 200 cycles");
    end
    tick();
    tick();
  endtask

  task automatic wait_data(input logic [31:0] v);
    int k;
    k = 0;
    @(negedge clk);
    while (data_tx_packet !== v && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("wait_data", data_tx_packet, v);
  endtask

  initial begin
    rst_n = 1'b0; node_id = 16'd1; max_node = 16'd4;
    wr_en = 1'b0; wr_data = '0; start = 1'b0; dest_node = '0; tx_grant = 1'b1;
    #12;
    chk("rst_ctrl", control_tx_packet, 32'h0);
    chk("rst_data", data_tx_packet, 32'h0);
    chk("rst_flags", {28'h0, tx_req, busy, done, err}, 32'h0);
    chk("rst_wr_ready", {31'h0, wr_ready}, 32'h1);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // 1: basic send
    write(16'h0005); write(16'h000A); write(16'h000B); write(16'h000C); write(16'h000D);
    push(0, 32'h00020005);
    push(1, 32'h00010005); push(1, 32'h0001000A); push(1, 32'h0001000B);
    push(1, 32'h0001000C); push(1, 32'h0001000D);
    push(2, 32'h1);
    send(16'd2);
    wait_idle();

    // 2: full buffer, ninth word dropped
    for (int i = 0; i < 8; i++) write(16'h0100 + 16'(i));
    chk("full_wr_ready", {31'h0, wr_ready}, 32'h0);
    write(16'h0108);
    push(0, 32'h00020008);
    for (int i = 0; i < 8; i++) push(1, 32'h00010100 + 32'(i));
    push(2, 32'h1);
    send(16'd2);
    wait_idle();

    // 3: invalid destinations
    write(16'h0033);
    push(3, 32'h1);
    send(16'd4);
    chk("bad_dest_busy", {31'h0, busy}, 32'h0);
    tick();
    write(16'h0034);
    push(3, 32'h1);
    send(16'd1);
    chk("self_dest_busy", {31'h0, busy}, 32'h0);
    tick();
    send(16'd2);                       // buffer flushed, so ignored
    chk("flushed_busy", {31'h0, busy}, 32'h0);
    tick();

    // 4: grant delay
    tx_grant = 1'b0;
    write(16'h0042); write(16'h0043);
    push(0, 32'h00030002);
    push(1, 32'h00010042); push(1, 32'h00010043);
    push(2, 32'h1);
    send(16'd3);
    for (int i = 0; i < 10; i++) begin
      chk("wait_req", {31'h0, tx_req}, 32'h1);
      chk("wait_pkts", control_tx_packet | data_tx_packet, 32'h0);
      tick();
    end
    tx_grant = 1'b1;
    tick();
    tx_grant = 1'b0;                   // dropping grant after acceptance is harmless
    chk("grant_ctrl_early", control_tx_packet, 32'h0);
    tick();
    chk("grant_ctrl", control_tx_packet, 32'h00030002);
    wait_idle();
    tx_grant = 1'b1;

    // 5: reset mid-DATA
    write(16'h0051); write(16'h0052); write(16'h0053); write(16'h0054);
    push(0, 32'h00020004);
    push(1, 32'h00010051); push(1, 32'h00010052);
    send(16'd2);
    wait_data(32'h00010052);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_data", data_tx_packet, 32'h0);
    chk("mid_rst_flags", {28'h0, tx_req, busy, done, err}, 32'h0);
    chk("mid_rst_wr_ready", {31'h0, wr_ready}, 32'h1);
    tick();
    rst_n = 1'b1;
    tick();
    write(16'h0061);
    push(0, 32'h00020001);
    push(1, 32'h00010061);
    push(2, 32'h1);
    send(16'd2);
    wait_idle();

    // 6: empty start ignored; write during DATA rejected
    send(16'd2);
    chk("empty_start_busy", {31'h0, busy}, 32'h0);
    tick();
    write(16'h0071); write(16'h0072);
    push(0, 32'h00020002);
    push(1, 32'h00010071); push(1, 32'h00010072);
    push(2, 32'h1);
    send(16'd2);
    wait_data(32'h00010071);
    wr_en = 1'b1;
    wr_data = 16'h0099;
    #1;
    chk("data_wr_ready", {31'h0, wr_ready}, 32'h0);
    tick();
    wr_en = 1'b0;
    wait_idle();
    write(16'h0081);
    push(0, 32'h00020001);
    push(1, 32'h00010081);
    push(2, 32'h1);
    send(16'd2);
    wait_idle();

    repeat (3) tick();
    chk("scoreboard_empty", exp_q.size(), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
